// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage: combinational grant,
// one-cycle read response routing. Define MEM_ARB_STARVE_GUARD_EN to build the fetch-starvation override.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_if,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } resp_state_e;

  resp_state_e state;
  resp_state_e state_nxt;
  logic        fetch_force;

  // The 4-bit starvation counter can only reach 1..15.
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  assign fetch_force = if_req && (starve_cnt == STARVE_LIM);

  // Counts consecutive cycles in which fetch asked and lost; any fetch grant or idle fetch clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign fetch_force = 1'b0;
`endif

  // Data wins by default; the starvation override is the only way fetch beats a data request.
  assign d_gnt    = d_req && !fetch_force;
  assign if_gnt   = if_req && !d_gnt;
  assign stall_if = if_req && !if_gnt;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end
  end

  // Response owner for next cycle; taken from every state so back-to-back reads pipeline.
  always_comb begin
    state_nxt = IDLE;
    if (if_gnt) begin
      state_nxt = RESP_IF;
    end else if (d_gnt && !d_we) begin
      state_nxt = RESP_D;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      if_rvalid <= (state_nxt == RESP_IF);
      d_rvalid  <= (state_nxt == RESP_D);
    end
  end

  // Read data is shared; consumers qualify it with their own rvalid.
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant rule, pending response slot, denial count).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_gnt, if_rvalid, stall_if;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: who owns next cycle's response (0 none, 1 fetch, 2 data), its address, fetch denial run.
  int            exp_resp = 0;
  logic [AW-1:0] exp_raddr = '0;
  int            denials = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .stall_if(stall_if),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_hash(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: read data for an address appears the cycle after the read; junk otherwise.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= rd_hash(mem_addr);
    else                   mem_rdata <= $urandom();
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of requests (called just after a rising edge), check at the falling edge.
  task automatic cycle(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    logic force_f, eg_d, eg_i, erd;
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    @(negedge clk);
    force_f = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    force_f = ir && (denials >= SM);
`endif
    eg_d = dr && !force_f;
    eg_i = ir && !eg_d;
    erd  = eg_d && !dw;
    check("if_gnt",    if_gnt,    eg_i);
    check("d_gnt",     d_gnt,     eg_d);
    check("stall_if",  stall_if,  ir && !eg_i);
    check("mem_en",    mem_en,    eg_i || eg_d);
    check("mem_we",    mem_we,    eg_d && dw);
    check("mem_addr",  mem_addr,  eg_d ? da : (eg_i ? ia : '0));
    check("mem_wdata", mem_wdata, eg_d ? dwd : '0);
    check("if_rvalid", if_rvalid, exp_resp == 1);
    check("d_rvalid",  d_rvalid,  exp_resp == 2);
    if (exp_resp == 1) check("if_rdata", if_rdata, rd_hash(exp_raddr));
    if (exp_resp == 2) check("d_rdata",  d_rdata,  rd_hash(exp_raddr));
    if (eg_i) begin
      exp_resp = 1; exp_raddr = ia;
    end else if (erd) begin
      exp_resp = 2; exp_raddr = da;
    end else begin
      exp_resp = 0;
    end
    if (ir && !eg_i) denials = (denials < SM) ? denials + 1 : SM;
    else             denials = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst if_rvalid", if_rvalid, 1'b0);
    check("rst d_rvalid",  d_rvalid,  1'b0);
    check("rst grants",    {if_gnt, d_gnt, stall_if}, 3'b000);
    check("rst mem",       {mem_en, mem_we}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fetch-only stream
    cycle(1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 32'h4, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 32'h8, 1'b0, 1'b0, '0, '0);
    idle();
    idle();

    // Simultaneous requests, then fetch retries
    cycle(1'b1, 32'h20, 1'b1, 1'b0, 32'h100, '0);
    cycle(1'b1, 32'h20, 1'b0, 1'b0, '0, '0);
    idle();

    // Store: no response follows; unaligned address passes through
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    idle();
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h43, '0);
    idle();

    // Continuous contention: exercises the starvation guard when built, strict priority otherwise
    for (int i = 0; i < 12; i++) cycle(1'b1, 32'h80, 1'b1, 1'b0, 32'h200 + 32'(i * 4), '0);
    idle();

    // Reset while a fetch read is outstanding
    cycle(1'b1, 32'h300, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    #1;
    check("mid-rst if_rvalid", if_rvalid, 1'b0);
    @(negedge clk);
    check("rst hold if_rvalid", if_rvalid, 1'b0);
    exp_resp = 0;
    denials  = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), $urandom(),
            1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)),
            $urandom(), $urandom());
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port data/instruction memory between the fetch stage (instruction reads) and the MEM stage (loads/stores). It returns read data to the correct requester one cycle after the grant, and generates a fetch stall when fetch loses arbitration. It sits between the core pipeline and the `memory` instance. Its sequential state is a response-owner tracker, an outstanding-read state machine, and an optional fetch-starvation counter.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_MAX`, default 4: consecutive fetch denials before fetch is forced through. Legal range 1..15. Used only with the configuration macro.

Ports (`reset`: asynchronous, active-high; clock `clk`):
- `clk`  in  1  clock
- `reset`  in  1  asynchronous active-high reset
- `if_req`  in  1  fetch read request
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch read data valid
- `if_rdata`  out  DATA_W  fetch read data
- `stall_if`  out  1  `if_req && !if_gnt`; holds PC and IF/ID
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  load data valid
- `d_rdata`  out  DATA_W  load data
- `mem_en`  out  1  memory access this cycle
- `mem_we`  out  1  memory write
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after a read access

## Operation
- At most one grant per cycle. `if_gnt` and `d_gnt` are never both 1.
- Grants are combinational from the requests and the current state:
  - default priority is data over fetch;
  - `if_gnt = if_req && !d_req`, `d_gnt = d_req`, except when the starvation override fires (see Configuration).
- Memory drive:
  - `mem_en = if_gnt | d_gnt`;
  - `mem_we = d_gnt & d_we`;
  - `mem_addr` and `mem_wdata` come from the granted requester;
  - with no grant, `mem_en = 0`, `mem_we = 0`, and `mem_addr` / `mem_wdata` drive 0.
- Addresses pass through unmodified, including the low 2 bits.
- Response FSM, registered:
  - States: IDLE, RESP_IF, RESP_D.
  - Next state is RESP_IF if `if_gnt`, RESP_D if `d_gnt && !d_we`, otherwise IDLE.
  - The transition is taken from every state, so back-to-back grants pipeline with no bubble.
- Outputs:
  - `if_rvalid = (state == RESP_IF)`;
  - `d_rvalid = (state == RESP_D)`;
  - `if_rdata = d_rdata = mem_rdata`; qualify with the corresponding rvalid.
- Stores return no response and produce no rvalid.
- A request not granted must be held stable by the requester until granted. The arbiter does not buffer requests.
- `stall_if` is asserted whenever fetch requests and is not granted.

## Timing
- Grant: same cycle as the request (0-cycle combinational path).
- Read latency: grant in cycle N gives rvalid in cycle N+1 with data from `mem_rdata`.
- Throughput: one access per cycle. A response for cycle N-1 and a new grant for cycle N coexist.
- Reset values:
  - state = IDLE, starvation counter = 0;
  - `if_rvalid = d_rvalid = 0`;
  - all grants and `mem_*` are 0 while requests are 0.
- Reset asserted with a read outstanding: the response is dropped, and no rvalid fires after reset deassertion.
- Simultaneous `if_req` and `d_req` with no override: data is granted, `stall_if = 1`, and fetch retries next cycle.
- A request deasserted before being granted leaves no state behind.

## Configuration
- Macro: `MEM_ARB_STARVE_GUARD_EN`.
- Defined:
  - A 4-bit counter increments each cycle where `if_req && !if_gnt`. It saturates at `STARVE_MAX`.
  - The counter clears on `if_gnt` or when `!if_req`.
  - When `counter == STARVE_MAX` and `if_req`, fetch is granted and `d_gnt = 0` that cycle, even if `d_req`. Data then stalls.
- Not defined:
  - The counter is not built.
  - Strict data-over-fetch priority applies. Fetch can starve indefinitely under continuous `d_req`.

## Test plan
- **Fetch-only stream:** `if_req = 1` with addresses 0x0, 0x4, 0x8 on consecutive cycles. Expect:
  - `if_gnt = 1` every cycle;
  - `if_rvalid = 1` on cycles 2–4 with `mem_rdata` matching each address;
  - `stall_if = 0` throughout.
- **Simultaneous requests:** `if_req = 1`, `d_req = 1`, `d_we = 0`, `d_addr = 0x100`. Expect:
  - `d_gnt = 1`, `if_gnt = 0`, `stall_if = 1`;
  - next cycle `d_rvalid = 1` and `if_rvalid = 0`.
- **Store:** `d_req = 1`, `d_we = 1`, `d_addr = 0x40`, `d_wdata = 0xDEADBEEF`. Expect:
  - `mem_en = 1`, `mem_we = 1`, `mem_addr = 0x40`, `mem_wdata = 0xDEADBEEF`;
  - no rvalid on the following cycle.
- **Starvation guard (macro defined, `STARVE_MAX = 4`):** `if_req` and `d_req` held high continuously. Expect:
  - data granted for 4 cycles, then `if_gnt = 1` and `d_gnt = 0` on the 5th;
  - the counter resets and the pattern repeats.
  - With the macro undefined, `if_gnt` stays 0 throughout.
- **Reset mid-read:** grant a fetch read, then assert `reset` in the next cycle. Expect:
  - `if_rvalid = 0` during reset and after release;
  - state returns to IDLE.
